mode_scheduler: RTL

Top-level mode controller for the digital clock. It owns the one-hot `enable[3:0]` mode bus that the clock counter, alarm, keypad time-set path and stopwatch consume, and it sequences the keypad time-set transaction. On entry to set mode it freezes the clock, waits for a committed keypad time, range-checks it, and issues a single load to the time counter. An idle timeout abandons an unfinished set.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/bcd_time_check.sv | 29 ++
 rtl/mode_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock blocks.
// Holds the one-hot mode encoding that every consumer of the mode bus
// decodes, plus the BCD upper limits used for range checks on
// hours/minutes/seconds.
package clock_pkg;

  // One-hot mode encoding; the scheduler drives these values directly
  // onto its enable bus.
  localparam logic [3:0] MODE_CLOCK  = 4'b0001;
  localparam logic [3:0] MODE_ALARM  = 4'b0010;
  localparam logic [3:0] MODE_SET    = 4'b0100;
  localparam logic [3:0] MODE_SWATCH = 4'b1000;

  // Largest legal packed-BCD values.
  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // Largest legal BCD digit.
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_time_check.sv
// Combinational range check of a packed-BCD time.
// Ports:
//   h, m, s : packed BCD hours/minutes/seconds, [7:4] tens, [3:0] units
//   ok      : 1 when every units digit is 0..9, h <= 23, m <= 59, s <= 59
// The tens digits need no separate test: the magnitude limits already
// bound them (a tens nibble above 2 or 5 exceeds the limit).
module bcd_time_check
  import clock_pkg::*;
(
  input  logic [7:0] h,
  input  logic [7:0] m,
  input  logic [7:0] s,
  output logic       ok
);

  logic units_ok;
  logic range_ok;

  assign units_ok = (h[3:0] <= BCD_DIGIT_MAX) &&
                    (m[3:0] <= BCD_DIGIT_MAX) &&
                    (s[3:0] <= BCD_DIGIT_MAX);

  assign range_ok = (h <= HOUR_MAX) &&
                    (m <= MINSEC_MAX) &&
                    (s <= MINSEC_MAX);

  assign ok = units_ok && range_ok;

endmodule

// File: rtl/mode_scheduler.sv
// Top-level mode controller for the digital clock.
// Owns the one-hot mode bus and sequences the keypad time-set transaction:
// in SET the time counter is frozen, a committed keypad time is range
// checked and, if legal, loaded into the time counter with a single pulse.
// An idle timeout (seconds without keypad activity) abandons the set.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   mode_btn           : 1-cycle pulse, advance CLOCK->ALARM->SET->SWATCH
//   tick_1hz           : 1-cycle pulse once per second
//   set_valid          : 1-cycle pulse, set_h/m/s committed by keypad path
//   set_h/m/s          : packed BCD keypad time
//   enable             : one-hot mode (registered state register itself)
//   run_clk            : time counter may advance (0 only in SET)
//   load               : 1-cycle pulse, time counter loads load_h/m/s
//   load_h/m/s         : last validated time, held between loads
//   set_err            : 1-cycle pulse, committed time failed range check
//
// Handshake: set_valid, mode_btn and tick_1hz are single-cycle strobes with
// no back-pressure; each strobe is acted on in the cycle it is high and the
// result is visible on the registered outputs in the following cycle.
module mode_scheduler
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       tick_1hz,
  input  logic       set_valid,
  input  logic [7:0] set_h,
  input  logic [7:0] set_m,
  input  logic [7:0] set_s,
  output logic [3:0] enable,
  output logic       run_clk,
  output logic       load,
  output logic [7:0] load_h,
  output logic [7:0] load_m,
  output logic [7:0] load_s,
  output logic       set_err
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT_S[7:0];

  logic [3:0] state;
  logic [3:0] next_state;
  logic [7:0] idle_cnt;
  logic [7:0] next_cnt;
  logic       time_ok;
  logic       do_load;
  logic       do_err;

  bcd_time_check u_check (
    .h  (set_h),
    .m  (set_m),
    .s  (set_s),
    .ok (time_ok)
  );

  // Next-state logic. Within SET the event priority is
  // set_valid > mode_btn > timeout.
  always_comb begin
    next_state = state;
    next_cnt   = 8'd0;
    do_load    = 1'b0;
    do_err     = 1'b0;
    case (state)
      MODE_CLOCK: begin
        if (mode_btn) next_state = MODE_ALARM;
      end
      MODE_ALARM: begin
        if (mode_btn) next_state = MODE_SET;
      end
      MODE_SET: begin
        next_cnt = idle_cnt;
        if (set_valid) begin
          next_cnt = 8'd0;
          if (time_ok) begin
            // A legal time wins over a coincident mode_btn.
            do_load    = 1'b1;
            next_state = MODE_CLOCK;
          end else begin
            do_err = 1'b1;
            if (mode_btn) next_state = MODE_SWATCH;
          end
        end else if (mode_btn) begin
          next_cnt   = 8'd0;
          next_state = MODE_SWATCH;
        end else if (tick_1hz) begin
          if (idle_cnt + 8'd1 == TIMEOUT_CNT) begin
            next_cnt   = 8'd0;
            next_state = MODE_CLOCK;
          end else begin
            next_cnt = idle_cnt + 8'd1;
          end
        end
      end
      MODE_SWATCH: begin
        if (mode_btn) next_state = MODE_CLOCK;
      end
      default: begin
        next_state = MODE_CLOCK;
      end
    endcase
  end

  // The idle counter is held at zero outside SET, so entering SET always
  // starts the count afresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MODE_CLOCK;
      idle_cnt <= 8'd0;
      run_clk  <= 1'b1;
      load     <= 1'b0;
      set_err  <= 1'b0;
      load_h   <= 8'h00;
      load_m   <= 8'h00;
      load_s   <= 8'h00;
    end else begin
      state    <= next_state;
      idle_cnt <= next_cnt;
      run_clk  <= (next_state != MODE_SET);
      load     <= do_load;
      set_err  <= do_err;
      if (do_load) begin
        load_h <= set_h;
        load_m <= set_m;
        load_s <= set_s;
      end
    end
  end

  assign enable = state;

endmodule
